// File: rtl/datapath_pkg.sv
// Shared constants for the multicycle MIPS-subset core: opcodes, functs,
// FSM state encodings and ALU operation codes.
package datapath_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_WB_R     = 4'd3,
        ST_EXEC_I   = 4'd4,
        ST_WB_I     = 4'd5,
        ST_MEM_ADDR = 4'd6,
        ST_MEM_RD   = 4'd7,
        ST_MEM_WB   = 4'd8,
        ST_MEM_WR   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JUMP     = 4'd11,
        ST_ERR      = 4'd12
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_t;

    function automatic logic funct_legal(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_AND) ||
               (funct == FN_OR)  || (funct == FN_SLT);
    endfunction

    function automatic alu_op_t funct_to_alu(input logic [5:0] funct);
        alu_op_t op;
        case (funct)
            FN_SUB:  op = ALU_SUB;
            FN_AND:  op = ALU_AND;
            FN_OR:   op = ALU_OR;
            FN_SLT:  op = ALU_SLT;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/banco_registros_p.sv
// Register file: two asynchronous read ports, one synchronous write port,
// register 0 hardwired to zero.
module banco_registros_p #(
    parameter int DATA_W = 32,
    parameter int REG_N  = 32,
    localparam int IDX_W = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [IDX_W-1:0]  raddr_a,
    input  logic [IDX_W-1:0]  raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata
);

    logic [DATA_W-1:0] regs [REG_N];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < REG_N; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : regs[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs[raddr_b];

endmodule

// File: rtl/datapath_multiciclo.sv
// Multicycle MIPS-subset core: one shared ALU and register file sequenced by
// an internal FSM, with fixed-latency instruction and data memory ports.
module datapath_multiciclo
    import datapath_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_N  = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_instr,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    output logic              dmem_we,
    output logic              dmem_re,
    input  logic [DATA_W-1:0] dmem_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic [3:0]        state,
    output logic              retire,
    output logic              err
);

    localparam int IDX_W = $clog2(REG_N);

    state_t            state_r;
    logic [31:0]       ir;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] target;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [DATA_W-1:0] alu_out;

    logic [5:0]        op;
    logic [IDX_W-1:0]  rs_idx;
    logic [IDX_W-1:0]  rt_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;
    logic [ADDR_W-1:0] jump_target;

    alu_op_t           alu_op;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_y;

    logic              rf_we;
    logic [IDX_W-1:0]  rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    assign op      = ir[31:26];
    assign rs_idx  = ir[21 +: IDX_W];
    assign rt_idx  = ir[16 +: IDX_W];
    assign rd_idx  = ir[11 +: IDX_W];
    assign imm_ext = {{(DATA_W-16){ir[15]}}, ir[15:0]};

    // Upper pc bits above the 28-bit jump field survive only when ADDR_W > 28.
    assign jump_target = ADDR_W'({64'(pc_r) >> 28, ir[25:0], 2'b00});

    assign imem_addr  = pc_r;
    assign pc         = pc_r;
    assign state      = state_r;
    assign dmem_addr  = ADDR_W'(alu_out);
    assign dmem_wdata = b_reg;

    banco_registros_p #(
        .DATA_W (DATA_W),
        .REG_N  (REG_N)
    ) u_regs (
        .clk     (clk),
        .reset   (reset),
        .raddr_a (rs_idx),
        .raddr_b (rt_idx),
        .rdata_a (rd_a),
        .rdata_b (rd_b),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata)
    );

    always_comb begin
        alu_op = ALU_ADD;
        alu_b  = imm_ext;
        if (state_r == ST_EXEC_R) begin
            alu_op = funct_to_alu(ir[5:0]);
            alu_b  = b_reg;
        end
        alu_y = a_reg + alu_b;
        case (alu_op)
            ALU_SUB: alu_y = a_reg - alu_b;
            ALU_AND: alu_y = a_reg & alu_b;
            ALU_OR:  alu_y = a_reg | alu_b;
            ALU_SLT: alu_y = DATA_W'($signed(a_reg) < $signed(alu_b));
            default: alu_y = a_reg + alu_b;
        endcase
    end

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = rd_idx;
        rf_wdata = alu_out;
        case (state_r)
            ST_WB_R: rf_we = 1'b1;
            ST_WB_I: begin
                rf_we    = 1'b1;
                rf_waddr = rt_idx;
            end
            ST_MEM_WB: begin
                rf_we    = 1'b1;
                rf_waddr = rt_idx;
                rf_wdata = dmem_rdata;
            end
            default: rf_we = 1'b0;
        endcase
    end

    // Strobes and retire are set on entry to their state so they are
    // registered and last exactly one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_FETCH;
            pc_r    <= '0;
            ir      <= '0;
            target  <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            alu_out <= '0;
            retire  <= 1'b0;
            dmem_we <= 1'b0;
            dmem_re <= 1'b0;
            err     <= 1'b0;
        end else begin
            retire  <= 1'b0;
            dmem_we <= 1'b0;
            dmem_re <= 1'b0;
            case (state_r)
                ST_FETCH: begin
                    ir      <= imem_instr;
                    pc_r    <= pc_r + ADDR_W'(4);
                    state_r <= ST_DECODE;
                end
                ST_DECODE: begin
                    a_reg  <= rd_a;
                    b_reg  <= rd_b;
                    target <= pc_r + ADDR_W'($signed({imm_ext, 2'b00}));
                    case (op)
                        OP_RTYPE: begin
                            if (funct_legal(ir[5:0])) begin
                                state_r <= ST_EXEC_R;
                            end else begin
                                state_r <= ST_ERR;
                                err     <= 1'b1;
                            end
                        end
                        OP_ADDI:      state_r <= ST_EXEC_I;
                        OP_LW, OP_SW: state_r <= ST_MEM_ADDR;
                        OP_BEQ: begin
                            state_r <= ST_BRANCH;
                            retire  <= 1'b1;
                        end
                        OP_J: begin
                            state_r <= ST_JUMP;
                            retire  <= 1'b1;
                        end
                        default: begin
                            state_r <= ST_ERR;
                            err     <= 1'b1;
                        end
                    endcase
                end
                ST_EXEC_R: begin
                    alu_out <= alu_y;
                    state_r <= ST_WB_R;
                    retire  <= 1'b1;
                end
                ST_EXEC_I: begin
                    alu_out <= alu_y;
                    state_r <= ST_WB_I;
                    retire  <= 1'b1;
                end
                ST_MEM_ADDR: begin
                    alu_out <= alu_y;
                    if (op == OP_LW) begin
                        state_r <= ST_MEM_RD;
                        dmem_re <= 1'b1;
                    end else begin
                        state_r <= ST_MEM_WR;
                        dmem_we <= 1'b1;
                        retire  <= 1'b1;
                    end
                end
                ST_MEM_RD: begin
                    state_r <= ST_MEM_WB;
                    retire  <= 1'b1;
                end
                ST_WB_R, ST_WB_I, ST_MEM_WB, ST_MEM_WR: state_r <= ST_FETCH;
                ST_BRANCH: begin
                    if (a_reg == b_reg) begin
                        pc_r <= target;
                    end
                    state_r <= ST_FETCH;
                end
                ST_JUMP: begin
                    pc_r    <= jump_target;
                    state_r <= ST_FETCH;
                end
                ST_ERR: state_r <= ST_ERR;
                default: begin
                    state_r <= ST_ERR;
                    err     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_datapath_multiciclo.sv
// Self-checking bench: runs a program table instruction by instruction and
// scoreboards every data-memory store, then covers reset and illegal cases.
module tb_datapath_multiciclo;

    localparam int DATA_W = 32;
    localparam int REG_N  = 32;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_instr;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_we;
    logic              dmem_re;
    logic [DATA_W-1:0] dmem_rdata = '0;
    logic [ADDR_W-1:0] pc;
    logic [3:0]        state;
    logic              retire;
    logic              err;

    int errors = 0;
    int checks = 0;

    datapath_multiciclo #(
        .DATA_W (DATA_W),
        .REG_N  (REG_N),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .imem_addr  (imem_addr),
        .imem_instr (imem_instr),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_we    (dmem_we),
        .dmem_re    (dmem_re),
        .dmem_rdata (dmem_rdata),
        .pc         (pc),
        .state      (state),
        .retire     (retire),
        .err        (err)
    );

    always #5 clk = ~clk;

    logic [31:0] imem [64];
    logic [31:0] dmem [64];

    assign imem_instr = imem[imem_addr[7:2]];

    always @(posedge clk) begin
        if (dmem_we) dmem[dmem_addr[7:2]] <= dmem_wdata;
        if (dmem_re) dmem_rdata <= dmem[dmem_addr[7:2]];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } store_t;
    store_t sb_q[$];

    always @(negedge clk) begin
        if (dmem_we) begin
            if (sb_q.size() == 0) begin
                check("unexpected_store", 1'b1, 1'b0);
            end else begin
                store_t s;
                s = sb_q.pop_front();
                check("store_addr", dmem_addr, s.addr);
                check("store_data", dmem_wdata, s.data);
            end
        end
    end

    function automatic logic [31:0] r_ins(input logic [5:0] fn, input int rd, input int rs, input int rt);
        return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] opc, input int rt, input int rs, input int imm);
        return {opc, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] j_ins(input int tgt);
        return {6'b000010, 26'(tgt)};
    endfunction

    localparam logic [5:0] ADDI = 6'b001000, LW = 6'b100011, SW = 6'b101011, BEQ = 6'b000100;
    localparam logic [5:0] F_ADD = 6'h20, F_SUB = 6'h22, F_AND = 6'h24, F_OR = 6'h25, F_SLT = 6'h2A;

    typedef struct {
        logic [7:0]  pc;
        logic [31:0] instr;
        int          cycles;
        logic [7:0]  next_pc;
        bit          st;
        logic [7:0]  st_addr;
        logic [31:0] st_data;
    } vec_t;
    vec_t prog[$];

    function automatic vec_t mk(input logic [7:0] p, input logic [31:0] ins, input int cyc,
                                input logic [7:0] nxt, input bit s, input logic [7:0] sa,
                                input logic [31:0] sd);
        vec_t v;
        v.pc = p; v.instr = ins; v.cycles = cyc; v.next_pc = nxt;
        v.st = s; v.st_addr = sa; v.st_data = sd;
        return v;
    endfunction

    // Entered at a negedge inside the instruction's FETCH cycle.
    task automatic run_instr(input string name, input int exp_cycles, input logic [7:0] exp_next);
        int cyc;
        bit done;
        cyc  = 1;
        done = 1'b0;
        for (int k = 0; k < 12 && !done; k++) begin
            @(negedge clk);
            cyc++;
            if (retire) done = 1'b1;
        end
        check({name, "_retired"}, done, 1'b1);
        check({name, "_cycles"}, cyc, exp_cycles);
        @(negedge clk);
        check({name, "_pc"}, pc, exp_next);
        check({name, "_retire_single"}, retire, 1'b0);
    endtask

    initial begin
        bit ok;
        for (int i = 0; i < 64; i++) begin
            imem[i] = 32'hFFFF_FFFF;
            dmem[i] = '0;
        end

        prog.push_back(mk(8'h00, i_ins(ADDI, 1, 0, 5),      4, 8'h04, 0, 8'h00, 32'h0));
        prog.push_back(mk(8'h04, i_ins(ADDI, 2, 0, 7),      4, 8'h08, 0, 8'h00, 32'h0));
        prog.push_back(mk(8'h08, r_ins(F_ADD, 3, 1, 2),     4, 8'h0C, 0, 8'h00, 32'h0));
        prog.push_back(mk(8'h0C, r_ins(F_SUB, 4, 1, 2),     4, 8'h10, 0, 8'h00, 32'h0));
        prog.push_back(mk(8'h10, r_ins(F_SLT, 5, 1, 2),     4, 8'h14, 0, 8'h00, 32'h0));
        prog.push_back(mk(8'h14, i_ins(SW, 3, 0, 8),        4, 8'h18, 1, 8'd8,  32'd12));
        prog.push_back(mk(8'h18, i_ins(SW, 4, 0, 12),       4, 8'h1C, 1, 8'd12, 32'hFFFF_FFFE));
        prog.push_back(mk(8'h1C, i_ins(SW, 5, 0, 16),       4, 8'h20, 1, 8'd16, 32'd1));
        prog.push_back(mk(8'h20, i_ins(BEQ, 2, 1, 5),       3, 8'h24, 0, 8'h00, 32'h0));
        prog.push_back(mk(8'h24, i_ins(LW, 6, 0, 8),        5, 8'h28, 0, 8'h00, 32'h0));
        prog.push_back(mk(8'h28, i_ins(SW, 6, 0, 20),       4, 8'h2C, 1, 8'd20, 32'd12));
        prog.push_back(mk(8'h2C, i_ins(ADDI, 0, 0, 9),      4, 8'h30, 0, 8'h00, 32'h0));
        prog.push_back(mk(8'h30, i_ins(SW, 0, 0, 24),       4, 8'h34, 1, 8'd24, 32'd0));
        prog.push_back(mk(8'h34, i_ins(ADDI, 8, 0, -1),     4, 8'h38, 0, 8'h00, 32'h0));
        prog.push_back(mk(8'h38, r_ins(F_SLT, 9, 8, 1),     4, 8'h3C, 0, 8'h00, 32'h0));
        prog.push_back(mk(8'h3C, r_ins(F_AND, 10, 1, 2),    4, 8'h40, 0, 8'h00, 32'h0));
        prog.push_back(mk(8'h40, r_ins(F_OR, 11, 1, 2),     4, 8'h44, 0, 8'h00, 32'h0));
        prog.push_back(mk(8'h44, i_ins(SW, 9, 0, 28),       4, 8'h48, 1, 8'd28, 32'd1));
        prog.push_back(mk(8'h48, i_ins(SW, 10, 0, 32),      4, 8'h4C, 1, 8'd32, 32'd5));
        prog.push_back(mk(8'h4C, i_ins(SW, 11, 0, 36),      4, 8'h50, 1, 8'd36, 32'd7));
        prog.push_back(mk(8'h50, i_ins(BEQ, 1, 1, 2),       3, 8'h5C, 0, 8'h00, 32'h0));
        prog.push_back(mk(8'h5C, j_ins(32'h3F),             3, 8'hFC, 0, 8'h00, 32'h0));
        prog.push_back(mk(8'hFC, i_ins(BEQ, 2, 1, 0),       3, 8'h00, 0, 8'h00, 32'h0));
        foreach (prog[i]) imem[prog[i].pc[7:2]] = prog[i].instr;

        repeat (2) @(negedge clk);
        check("rst_pc", pc, 8'h00);
        check("rst_imem_addr", imem_addr, 8'h00);
        check("rst_state", state, 4'd0);
        check("rst_err", err, 1'b0);
        check("rst_retire", retire, 1'b0);
        check("rst_we", dmem_we, 1'b0);
        check("rst_re", dmem_re, 1'b0);
        reset = 1'b0;

        foreach (prog[i]) begin
            if (prog[i].st) sb_q.push_back('{addr: prog[i].st_addr, data: prog[i].st_data});
            run_instr($sformatf("prog%0d", i), prog[i].cycles, prog[i].next_pc);
        end
        check("stores_drained", sb_q.size(), 0);

        // Backward branch: j to 0x20, then beq $1,$1,-2 lands on 0x1C.
        reset = 1'b1;
        imem[0] = j_ins(8);
        imem[8] = i_ins(BEQ, 1, 1, -2);
        @(negedge clk);
        reset = 1'b0;
        run_instr("jmp_0x20", 3, 8'h20);
        run_instr("beq_back", 3, 8'h1C);

        // Reset while an R-type sits in EXEC_R.
        reset = 1'b1;
        imem[0] = i_ins(ADDI, 1, 0, 5);
        imem[1] = r_ins(F_ADD, 3, 1, 1);
        @(negedge clk);
        reset = 1'b0;
        run_instr("pre_add", 4, 8'h04);
        repeat (2) @(negedge clk);
        check("mid_exec_state", state, 4'd2);
        reset = 1'b1;
        #1;
        check("mid_rst_pc", pc, 8'h00);
        check("mid_rst_state", state, 4'd0);
        check("mid_rst_err", err, 1'b0);
        check("mid_rst_retire", retire, 1'b0);
        @(negedge clk);
        imem[0] = i_ins(SW, 3, 0, 8);
        sb_q.push_back('{addr: 8'd8, data: 32'd0});
        reset = 1'b0;
        run_instr("after_rst_sw", 4, 8'h04);
        check("after_rst_drained", sb_q.size(), 0);

        // Illegal opcode: ERR is terminal until reset.
        reset = 1'b1;
        imem[0] = 32'hFC00_0000;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("ill_decode_state", state, 4'd1);
        check("ill_decode_err", err, 1'b0);
        @(negedge clk);
        check("ill_err", err, 1'b1);
        check("ill_state", state, 4'd12);
        ok = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (!(err === 1'b1 && state === 4'd12 && retire === 1'b0 && dmem_we === 1'b0)) ok = 1'b0;
        end
        check("ill_sticky", ok, 1'b1);
        reset = 1'b1;
        #1;
        check("ill_rst_err", err, 1'b0);

        // Illegal funct on an R-type opcode.
        imem[0] = r_ins(6'h3F, 3, 1, 2);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("ill_funct_err", err, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/datapath_multiciclo.md
# datapath_multiciclo

Parametrised multicycle MIPS-subset datapath: the successor to the single-cycle R-type datapath. It adds I-type, load/store, branch and jump support, and drives everything from an internal control state machine, so one ALU and one register file are shared across cycles. It sits between an external instruction memory and an external data memory, both attached through simple fixed-latency ports. It is the processor core used by the next top-level integration.

## Interface
Parameters:
- DATA_W, 32, datapath/register width; legal range 32..64; the 16-bit immediate is sign-extended to DATA_W
- REG_N, 32, number of architectural registers; power of two, ≤32; register index = instr field [log2(REG_N)-1:0]
- ADDR_W, 8, PC and data-address width in bytes

Ports (one clock; reset is asynchronous and active-high):
- clk, in, 1, rising-edge clock
- reset, in, 1, asynchronous, active-high
- imem_addr, out, ADDR_W, equals pc
- imem_instr, in, 32, combinational instruction read; sampled at the end of FETCH
- dmem_addr, out, ADDR_W, ALU result low bits
- dmem_wdata, out, DATA_W, rt value
- dmem_we, out, 1, write strobe, one cycle
- dmem_re, out, 1, read strobe; data valid on dmem_rdata the next cycle
- dmem_rdata, in, DATA_W, load data
- pc, out, ADDR_W, program counter
- state, out, 4, current FSM state encoding (debug)
- retire, out, 1, one-cycle pulse in the last cycle of each instruction
- err, out, 1, sticky illegal-instruction flag

## Operation
Supported instructions:
- R-type, op 000000; funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt (signed)
- addi 001000
- lw 100011
- sw 101011
- beq 000100
- j 000010
- Any other op or funct → ERR

FSM states:
- FETCH: latch IR ← imem_instr; pc ← pc+4
- DECODE: A ← rs, B ← rt; precompute branch target = pc + (sext(imm)<<2)
- Transitions out of DECODE:
  - R → EXEC_R → WB_R
  - addi → EXEC_I → WB_I
  - lw/sw → MEM_ADDR; then lw → MEM_RD → MEM_WB, sw → MEM_WR
  - beq → BRANCH
  - j → JUMP
  - illegal → ERR
- Writeback destinations: WB_R writes rd, WB_I writes rt, MEM_WB writes rt with dmem_rdata
- BRANCH: if A == B then pc ← target
- JUMP: pc ← {pc[ADDR_W-1:28 clipped], IR[25:0]<<2} truncated to ADDR_W
- After WB_R, WB_I, MEM_WB, MEM_WR, BRANCH, JUMP → FETCH; retire=1 in that cycle
- ERR: terminal; err=1; no register or memory writes; leaves only on reset

Rules:
- Arithmetic wraps modulo 2^DATA_W; no overflow trap
- pc wraps modulo 2^ADDR_W (pc = 2^ADDR_W−4 followed by +4 gives 0)
- Register 0 always reads 0; writes to it are discarded
- Branch comparison uses the A/B latched in DECODE
- Reset values: pc=0, state=FETCH, err=0, retire=0, dmem_we=0, dmem_re=0, IR=0, all registers=0

## Timing
- Cycles per instruction: R/addi 4, sw 4, lw 5, beq 3, j 3
- dmem_re is asserted in MEM_RD only; dmem_rdata is captured in MEM_WB, the following cycle
- dmem_we is asserted in MEM_WR only; dmem_addr and dmem_wdata are stable in the same cycle
- Register writes take effect at the rising edge that ends the WB state; they are visible to the next instruction's DECODE
- Reset asserted mid-instruction: every output returns to its reset value immediately, the partial instruction is abandoned and no write completes
- After reset deassertion, the first rising edge executes FETCH at pc=0

## Structure
- Shared package/include datapath_pkg:
  - opcode and funct constants
  - FSM state encodings (4 bits)
  - ALU operation codes (3 bits)
- Sub-module banco_registros_p:
  - parametrised by DATA_W and REG_N
  - two asynchronous read ports, one synchronous write port
  - asynchronous reset to zero
  - reg0 forced to zero
- ALU and control are implemented inside the top module

## Test plan
- Reset: assert reset mid-EXEC_R → pc=0, state=FETCH, err=0; the pending rd write does not occur.
- R-type: $1=5, $2=7 (via addi); add $3,$1,$2 → $3=12 after 4 cycles, retire pulses once. sub $4,$1,$2 → 0xFFFFFFFE. slt $5,$1,$2 → 1.
- Memory: sw $3,8($0) → dmem_we=1 with dmem_addr=8, dmem_wdata=12. lw $6,8($0) with the memory model returning 12 → $6=12 on the 5th cycle.
- Branch: beq $1,$1,−2 at pc=0x20 → pc=0x1C after 3 cycles; beq $1,$2,x → pc=0x24.
- Jump and wrap: j to 0x3F (ADDR_W=8) → pc=0xFC; next FETCH → pc=0x00. addi $0,$0,9 → $0 stays 0.
- Illegal: op 111111 → err=1 in the cycle after DECODE; it stays 1 with no dmem_we and no register writes until reset.
